// File: rtl/fas_pkg.sv
// Shared FFT-output-interface definitions: bin count, widths, bin word layout and
// the peak detector's state encoding.
package fas_pkg;

  localparam int FFT_NBINS = 16;
  localparam int FFT_DW    = 16;
  localparam int MAGW      = 2 * FFT_DW + 1;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } fft_word_t;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

endpackage

// File: rtl/fpd_mag_sq.sv
// Combinational magnitude-squared of one FFT bin: re*re + im*im, unsigned MAGW bits.
module fpd_mag_sq
  import fas_pkg::*;
(
  input  logic [2*FFT_DW-1:0] word,
  output logic [MAGW-1:0]     mag
);

  fft_word_t          w;
  logic signed [31:0] re_x;
  logic signed [31:0] im_x;
  logic signed [31:0] re_sq;
  logic signed [31:0] im_sq;

  assign w     = word;
  assign re_x  = 32'(w.re);
  assign im_x  = 32'(w.im);
  // Each square is at most 2^30, so 32 signed bits hold it exactly.
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign mag   = MAGW'(unsigned'(re_sq)) + MAGW'(unsigned'(im_sq));

endmodule

// File: rtl/fft_peak_detector.sv
// Captures a 16-bin FFT frame and scans one bin per cycle for the peak magnitude.
// Optional macro FPD_DC_SKIP_EN excludes bin 0 from the search.
module fft_peak_detector
  import fas_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic        overrun
);

`ifdef FPD_DC_SKIP_EN
  localparam logic [3:0] INIT_IDX = 4'd1;
`else
  localparam logic [3:0] INIT_IDX = 4'd0;
`endif

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      idx;
  logic [3:0]      best_idx;
  logic [MAGW-1:0] best_mag;
  logic [MAGW-1:0] mag;
  logic [31:0]     bank [FFT_NBINS];
  logic            load;
  logic            drop;
  logic            last;
  logic            better;

  fpd_mag_sq u_mag_sq (
    .word (bank[idx]),
    .mag  (mag)
  );

`ifdef FPD_DC_SKIP_EN
  assign better = (mag > best_mag) && (idx != 4'd0);
`else
  assign better = (mag > best_mag);
`endif

  assign last = (state == SCAN) && (idx == 4'(FFT_NBINS - 1));

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (fft_valid) begin
          load      = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (last) begin
          if (fft_valid) load = 1'b1;
          else           state_nxt = IDLE;
        end else if (fft_valid) begin
          drop = 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      best_idx <= '0;
      best_mag <= '0;
      done     <= 1'b0;
      freq     <= '0;
      overrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= last;
      if (drop) overrun <= 1'b1;
      if (last) freq <= better ? idx : best_idx;
      if (load) begin
        idx      <= '0;
        best_mag <= '0;
        best_idx <= INIT_IDX;
      end else if (state == SCAN) begin
        idx <= idx + 4'd1;
        if (better) begin
          best_mag <= mag;
          best_idx <= idx;
        end
      end
    end
  end

  // NOTE: the capture bank is plain storage, always written before it is read,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      bank[0]  <= fft_d0;
      bank[1]  <= fft_d1;
      bank[2]  <= fft_d2;
      bank[3]  <= fft_d3;
      bank[4]  <= fft_d4;
      bank[5]  <= fft_d5;
      bank[6]  <= fft_d6;
      bank[7]  <= fft_d7;
      bank[8]  <= fft_d8;
      bank[9]  <= fft_d9;
      bank[10] <= fft_d10;
      bank[11] <= fft_d11;
      bank[12] <= fft_d12;
      bank[13] <= fft_d13;
      bank[14] <= fft_d14;
      bank[15] <= fft_d15;
    end
  end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Scoreboard bench for fft_peak_detector: expected peaks queued at frame launch,
// checked with their due cycle when done pulses. Honours FPD_DC_SKIP_EN.
module tb_fft_peak_detector;

  typedef struct {
    logic [3:0] freq;
    int         due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        done;
  logic [3:0]  freq;
  logic        overrun;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb [$];

`ifdef FPD_DC_SKIP_EN
  localparam bit DC_SKIP = 1'b1;
`else
  localparam bit DC_SKIP = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_peak_detector dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .freq(freq), .overrun(overrun)
  );

  // Every done pulse must match the oldest queued frame, on exactly its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected cyc=%0d freq=%0d, required no done pulse", cyc, freq);
      end else begin
        e = sb.pop_front();
        if (freq !== e.freq || cyc != e.due) begin
          failures++;
          $display("FAIL done_result cyc=%0d freq=%0d, required cyc=%0d freq=%0d",
                   cyc, freq, e.due, e.freq);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d, required completion before time limit", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] model_peak(input logic [31:0] f [16]);
    longint best = 0;
    longint m;
    int     re, im;
    logic [3:0] bi = DC_SKIP ? 4'd1 : 4'd0;
    for (int k = (DC_SKIP ? 1 : 0); k < 16; k++) begin
      re = $signed(f[k][31:16]);
      im = $signed(f[k][15:0]);
      m  = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (m > best) begin
        best = m;
        bi   = 4'(k);
      end
    end
    return bi;
  endfunction

  // Called at a negedge; the following posedge samples the frame.
  task automatic send(input logic [31:0] f [16], input bit accept, input logic [3:0] exp_freq);
    exp_t e;
    d         = f;
    fft_valid = 1'b1;
    @(negedge clk);
    fft_valid = 1'b0;
    if (accept) begin
      e.freq = exp_freq;
      e.due  = cyc + 16;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d, required 0 pending results", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_freq(input string name, input logic [3:0] exp_freq);
    checks++;
    if (freq !== exp_freq) begin
      failures++;
      $display("FAIL %s freq=%0d, required %0d", name, freq, exp_freq);
    end
  endtask

  task automatic check_overrun(input string name, input logic exp_ov);
    checks++;
    if (overrun !== exp_ov) begin
      failures++;
      $display("FAIL %s overrun=%0b, required %0b", name, overrun, exp_ov);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    fft_valid = 1'b0;
    for (int k = 0; k < 16; k++) d[k] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || freq !== 4'd0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset done=%0b freq=%0d overrun=%0b, required 0 0 0", done, freq, overrun);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] f [16] = '{default: '0};
    f[1] = 32'h0100_0000;
    send(f, 1'b1, 4'd1);
    wait_drain("single");
    check_freq("single_hold", 4'd1);
  endtask

  task automatic test_tie();
    logic [31:0] f [16] = '{default: '0};
    f[1]  = 32'h0000_0200;
    f[15] = 32'h0000_0200;
    send(f, 1'b1, 4'd1);
    wait_drain("tie");
  endtask

  task automatic test_negative();
    logic [31:0] f [16] = '{default: '0};
    f[7] = 32'h8000_8000;
    f[3] = 32'h7FFF_7FFF;
    send(f, 1'b1, 4'd7);
    wait_drain("negative");
    check_freq("negative_hold", 4'd7);
  endtask

  task automatic test_zero();
    logic [31:0] f [16] = '{default: '0};
    send(f, 1'b1, DC_SKIP ? 4'd1 : 4'd0);
    wait_drain("zero");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [16] = '{default: '0};
    logic [31:0] b [16] = '{default: '0};
    a[1]  = 32'h0040_0000;
    b[15] = 32'hFF00_0100;
    send(a, 1'b1, 4'd1);
    repeat (15) @(negedge clk);
    send(b, 1'b1, 4'd15);
    wait_drain("back_to_back");
    check_overrun("back_to_back_overrun", 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] f [16];
    int gap;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 16; k++)
        f[k] = n[0] ? ($urandom() & 32'h0003_0003) : $urandom();
      gap = (n % 3 == 0) ? 0 : int'($urandom_range(1, 4));
      send(f, 1'b1, model_peak(f));
      repeat (15 + gap) @(negedge clk);
    end
    wait_drain("random");
    check_overrun("random_overrun", 1'b0);
  endtask

  task automatic test_overrun();
    logic [31:0] a [16] = '{default: '0};
    logic [31:0] b [16] = '{default: '0};
    a[3] = 32'h0000_0300;
    b[9] = 32'h7000_7000;
    send(a, 1'b1, 4'd3);
    repeat (4) @(negedge clk);
    send(b, 1'b0, 4'd0);
    wait_drain("overrun");
    check_overrun("overrun_sticky", 1'b1);
    check_freq("overrun_first_intact", 4'd3);
    repeat (5) @(negedge clk);
    check_overrun("overrun_still_set", 1'b1);
  endtask

  task automatic test_rst_mid();
    logic [31:0] f [16] = '{default: '0};
    f[5] = 32'h0500_0000;
    send(f, 1'b0, 4'd0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (24) @(negedge clk);
    check_freq("rst_mid_freq", 4'd0);
    check_overrun("rst_mid_overrun", 1'b0);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_done done=%0b, required 0", done);
    end
  endtask

  task automatic test_dc_skip();
    logic [31:0] f [16] = '{default: '0};
    f[0] = 32'h7FFF_0000;
    f[4] = 32'h0010_0000;
    send(f, 1'b1, DC_SKIP ? 4'd4 : 4'd0);
    wait_drain("dc_skip");
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_negative();
    test_zero();
    test_back_to_back();
    test_random();
    test_overrun();
    test_rst_mid();
    test_dc_skip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
